// File: rtl/fetch_port_pkg.sv
// fetch_port_pkg: shared types and constants for the instruction-fetch responder
package fetch_port_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam int WORD_BYTES = 4;
    localparam int TAG_W = 29;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    function automatic logic [TAG_W-1:0] tag_of(input logic [31:2] word);
        return word[31:3];
    endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry direct-mapped word store with lookup, probe, one write port and clear
module fetch_buffer
    import fetch_port_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:2] lookup_addr,
    output logic        lookup_hit,
    output logic [31:0] lookup_data,
    input  logic [31:2] probe_addr,
    output logic        probe_hit,
    input  logic        wr_en,
    input  logic [31:2] wr_addr,
    input  logic [31:0] wr_data
);
    logic [1:0]       valid;
    logic [TAG_W-1:0] tag  [2];
    logic [31:0]      data [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid <= '0;
        else if (clear) valid <= '0;
        else if (wr_en) valid[wr_addr[2]] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag[wr_addr[2]]  <= tag_of(wr_addr);
            data[wr_addr[2]] <= wr_data;
        end
    end

    assign lookup_hit  = valid[lookup_addr[2]] && tag[lookup_addr[2]] == tag_of(lookup_addr);
    assign lookup_data = lookup_hit ? data[lookup_addr[2]] : '0;
    assign probe_hit   = valid[probe_addr[2]] && tag[probe_addr[2]] == tag_of(probe_addr);
endmodule

// File: rtl/fetch_port.sv
// fetch_port: fetch responder serving lookups from a word buffer filled and prefetched over req/ack
module fetch_port
    import fetch_port_pkg::*;
#(
    parameter bit PREFETCH        = 1'b1,
    parameter int MEM_LATENCY_MAX = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic        invalidate_all,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_timeout
);
    localparam int WD_W = MEM_LATENCY_MAX > 0 ? $clog2(MEM_LATENCY_MAX + 1) : 1;

    state_t      state, state_nx;
    logic        drop, hit, pf_hit, fill, req_nx;
    logic [31:2] mem_word, addr_nx, pf_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^fetch_address[1:0];
    assign pf_word  = fetch_address[31:2] + 30'd1;
    // a response issued before an invalidate must never land in the buffer
    assign fill     = state == BUSY && mem_ack && !drop && !invalidate_all;
    assign mem_addr = {mem_word, 2'b00};

    fetch_buffer u_buf (
        .clk         (clk),
        .reset       (reset),
        .clear       (invalidate_all),
        .lookup_addr (fetch_address[31:2]),
        .lookup_hit  (hit),
        .lookup_data (fetch_data),
        .probe_addr  (pf_word),
        .probe_hit   (pf_hit),
        .wr_en       (fill),
        .wr_addr     (mem_word),
        .wr_data     (mem_rdata)
    );

    assign fetch_ready = hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_word <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_req  <= req_nx;
            mem_word <= addr_nx;
            drop     <= state == BUSY && !mem_ack && (drop || invalidate_all);
        end
    end

    always_comb begin
        state_nx = state == BUSY ? (mem_ack ? IDLE : BUSY)
                                 : ((!hit || (PREFETCH && !pf_hit)) ? BUSY : IDLE);
    end

    // demand miss wins over prefetch; the address only moves when a new request starts
    always_comb begin
        req_nx  = state_nx == BUSY;
        addr_nx = (state == IDLE && state_nx == BUSY) ? (hit ? pf_word : fetch_address[31:2])
                                                      : mem_word;
    end

    if (MEM_LATENCY_MAX > 0) begin : g_wd
        logic [WD_W-1:0] wd_cnt;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wd_cnt      <= '0;
                bus_timeout <= 1'b0;
            end else if (state != BUSY || mem_ack) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_W'(MEM_LATENCY_MAX)) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_W'(MEM_LATENCY_MAX - 1)) bus_timeout <= 1'b1;
            end
        end
    end else begin : g_no_wd
        assign bus_timeout = 1'b0;
    end
endmodule
